// File: rtl/packet_serializer.sv
// Serial packet engine: frames {opcode, address, data} MSB-first, paces the address counter,
// and captures the returned byte in PLAY mode. Define STOP_AT_END_EN to stop automatically at END_ADDR.
module packet_serializer #(
    parameter logic [7:0]  REC_OP   = 8'h02,
    parameter logic [7:0]  PLAY_OP  = 8'h03,
    parameter logic [7:0]  SETUP_OP = 8'h06,
    parameter logic [15:0] END_ADDR = 16'd62720
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Rec_butt,
    input  logic        Play_butt,
    input  logic        Stop_butt,
    input  logic [15:0] address,
    input  logic [7:0]  sample_in,
    input  logic        sdi,
    output logic        sdo,
    output logic        cs_n,
    output logic [4:0]  thirty_two_count,
    output logic        prepacket,
    output logic [7:0]  sample_out,
    output logic        sample_valid,
    output logic        busy
);

`ifdef STOP_AT_END_EN
    localparam bit AUTO_STOP = 1'b1;
`else
    localparam bit AUTO_STOP = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, GAP, SETUP, STREAM, FINISH} state_t;
    typedef enum logic {RECORD, PLAY} mode_t;

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        stop_q, stop_d;
    logic [7:0]  cap_q, cap_d;
    logic [7:0]  sample_out_q, sample_out_d;
    logic        sample_valid_q, sample_valid_d;

    logic        shifting;
    logic        start;
    mode_t       start_mode;
    logic [7:0]  opcode;
    logic [31:0] pkt_word;
    logic [31:0] tx_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            mode_q         <= RECORD;
            cnt_q          <= 5'd0;
            shift_q        <= 32'd0;
            stop_q         <= 1'b0;
            cap_q          <= 8'h00;
            sample_out_q   <= 8'h00;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            stop_q         <= stop_d;
            cap_q          <= cap_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        stop_d         = stop_q;
        cap_d          = cap_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;

        shifting   = (state_q == SETUP) || (state_q == STREAM);
        start      = Rec_butt || Play_butt;
        start_mode = Rec_butt ? RECORD : PLAY;
        opcode     = (state_q == SETUP) ? SETUP_OP : ((mode_q == PLAY) ? PLAY_OP : REC_OP);
        pkt_word   = {opcode, address, (mode_q == RECORD) ? sample_in : 8'h00};
        // Word is taken live at count 0 so the address reflects the counter's update at count 31.
        tx_word    = (cnt_q == 5'd0) ? pkt_word : shift_q;

        sdo       = shifting && tx_word[31];
        cs_n      = !shifting;
        prepacket = (state_q == SETUP) && (cnt_q == 5'd31);
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = GAP;
                    mode_d  = start_mode;
                    cnt_d   = 5'd0;
                    stop_d  = 1'b0;
                end
            end
            GAP: begin
                state_d = SETUP;
                cnt_d   = 5'd0;
            end
            SETUP, STREAM: begin
                shift_d = {tx_word[30:0], 1'b0};
                cnt_d   = cnt_q + 5'd1;
                if (Stop_butt) stop_d = 1'b1;
                if (AUTO_STOP && state_q == STREAM && cnt_q == 5'd0 && address == END_ADDR)
                    stop_d = 1'b1;
                if (state_q == STREAM && mode_q == PLAY && cnt_q >= 5'd24)
                    cap_d = {cap_q[6:0], sdi};
                if (cnt_q == 5'd31) begin
                    state_d = stop_d ? FINISH : STREAM;
                    if (state_q == STREAM && mode_q == PLAY) begin
                        sample_out_d   = {cap_q[6:0], sdi};
                        sample_valid_d = 1'b1;
                    end
                end
                // A new start abandons the packet in flight, including its capture.
                if (start) begin
                    state_d        = GAP;
                    mode_d         = start_mode;
                    cnt_d          = 5'd0;
                    stop_d         = 1'b0;
                    sample_out_d   = sample_out_q;
                    sample_valid_d = 1'b0;
                end
            end
            FINISH: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
                stop_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign thirty_two_count = cnt_q;
    assign sample_out       = sample_out_q;
    assign sample_valid     = sample_valid_q;

endmodule

// File: tb/tb_packet_serializer.sv
// Randomized scoreboard bench for packet_serializer: stimulus queues expected packets, samples
// and cycle checks; a negedge monitor reassembles serial words and compares in order.
module tb_packet_serializer;

    localparam logic [15:0] END_ADDR = 16'd62720;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Rec_butt = 1'b0, Play_butt = 1'b0, Stop_butt = 1'b0;
    logic [15:0] address = 16'h8000;
    logic [7:0]  sample_in = 8'h00;
    logic        sdi = 1'b0;
    logic        sdo, cs_n, prepacket, sample_valid, busy;
    logic [4:0]  thirty_two_count;
    logic [7:0]  sample_out;

    packet_serializer dut (
        .clk(clk), .reset(reset), .Rec_butt(Rec_butt), .Play_butt(Play_butt),
        .Stop_butt(Stop_butt), .address(address), .sample_in(sample_in), .sdi(sdi),
        .sdo(sdo), .cs_n(cs_n), .thirty_two_count(thirty_two_count), .prepacket(prepacket),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic        pre;
    } pkt_t;

    pkt_t        word_q[$];
    logic [7:0]  samp_q[$];
    string       chk_name_q[$];
    logic [31:0] chk_act_q[$];
    logic [31:0] chk_exp_q[$];

    int n_cmp = 0, n_err = 0;
    int pkts_done = 0;
    int sess_base = 0;
    logic [15:0] sess_addr[8];
    logic [7:0]  sess_sdi = 8'h00;

    function automatic void push_chk(string n, logic [31:0] a, logic [31:0] e);
        chk_name_q.push_back(n);
        chk_act_q.push_back(a);
        chk_exp_q.push_back(e);
    endfunction

    function automatic void cmp(string n, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
        end
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom);
        if (a == END_ADDR) a = a ^ 16'h0001;
        return a;
    endfunction

    // Monitor: the only process that scores.
    logic [31:0] acc = 32'd0;
    pkt_t        mon_p;
    always @(negedge clk) begin
        while (chk_name_q.size() > 0)
            cmp(chk_name_q.pop_front(), chk_act_q.pop_front(), chk_exp_q.pop_front());
        if (!cs_n) begin
            acc[31 - int'(thirty_two_count)] = sdo;
            if (thirty_two_count == 5'd31) begin
                if (word_q.size() == 0) cmp("unexpected_packet", acc, 32'hxxxx_xxxx);
                else begin
                    mon_p = word_q.pop_front();
                    cmp("packet_word", acc, mon_p.word);
                    cmp("prepacket_last_bit", {31'd0, prepacket}, {31'd0, mon_p.pre});
                end
                pkts_done++;
            end else if (prepacket) begin
                cmp("prepacket_stray", {31'd0, prepacket}, 32'd0);
            end
        end else if (thirty_two_count != 5'd0) begin
            cmp("count_when_deselected", {27'd0, thirty_two_count}, 32'd0);
        end
        if (sample_valid) begin
            if (samp_q.size() == 0) cmp("unexpected_sample_valid", {24'd0, sample_out}, 32'hxxxx_xxxx);
            else cmp("sample_out", {24'd0, sample_out}, {24'd0, samp_q.pop_front()});
        end
    end

    // Memory / address-counter model: per-packet address table, sdi returns sess_sdi on counts 24..31.
    int drv_idx;
    always @(posedge clk) begin
        #1;
        drv_idx = pkts_done - sess_base;
        if (drv_idx < 0) drv_idx = 0;
        if (drv_idx > 7) drv_idx = 7;
        address = sess_addr[drv_idx];
        if (!cs_n && thirty_two_count >= 5'd24)
            sdi = sess_sdi[31 - int'(thirty_two_count)];
        else
            sdi = 1'($urandom);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_for(input int tgt, input int k);
        int n;
        n = 0;
        while (!(!cs_n && pkts_done == tgt && int'(thirty_two_count) == k) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) push_chk("wait_timeout", 32'd1, 32'd0);
    endtask

    // ncomp = packets (setup included) that run to count 31. rst_end: return at count k of the
    // next packet so the following session's start button aborts it; else Stop at count k of the last.
    task automatic session(input bit play, input bit both, input logic [15:0] a0,
                           input logic [7:0] s, input logic [7:0] b,
                           input int ncomp, input bit rst_end, input int k);
        pkt_t p;
        sess_base    = pkts_done;
        sess_addr[0] = a0;
        for (int i = 1; i < 8; i++) sess_addr[i] = rand_addr();
        sess_sdi  = b;
        sample_in = s;
        for (int i = 0; i < ncomp; i++) begin
            p.word = {(i == 0) ? 8'h06 : (play ? 8'h03 : 8'h02), sess_addr[i], play ? 8'h00 : s};
            p.pre  = (i == 0);
            word_q.push_back(p);
        end
        if (play) for (int i = 1; i < ncomp; i++) samp_q.push_back(b);
        Rec_butt  = !play;
        Play_butt = play | both;
        Stop_butt = 1'($urandom);
        tick();
        Rec_butt = 1'b0; Play_butt = 1'b0; Stop_butt = 1'b0;
        push_chk("gap_cycle", {25'd0, cs_n, busy, thirty_two_count}, {25'd0, 1'b1, 1'b1, 5'd0});
        tick();
        push_chk("setup_start", {26'd0, cs_n, thirty_two_count}, 32'd0);
        if (rst_end) begin
            wait_for(sess_base + ncomp, k);
            return;
        end
        wait_for(sess_base + ncomp - 1, k);
        Stop_butt = 1'b1;
        tick();
        Stop_butt = 1'b0;
        wait_for(sess_base + ncomp - 1, 31);
        tick();
        push_chk("finish_cycle", {25'd0, cs_n, busy, thirty_two_count}, {25'd0, 1'b1, 1'b1, 5'd0});
        tick();
        push_chk("idle_after_finish", {30'd0, cs_n, busy}, {30'd0, 1'b1, 1'b0});
    endtask

    task automatic end_addr_test();
        pkt_t p;
        sess_base    = pkts_done;
        sess_addr[0] = 16'h8000;
        sess_addr[1] = END_ADDR;
        for (int i = 2; i < 8; i++) sess_addr[i] = rand_addr();
        sample_in = 8'h33;
        for (int i = 0; i < 3; i++) begin
            p.word = {(i == 0) ? 8'h06 : 8'h02, sess_addr[i], 8'h33};
            p.pre  = (i == 0);
`ifdef STOP_AT_END_EN
            if (i < 2) word_q.push_back(p);
`else
            word_q.push_back(p);
`endif
        end
        Rec_butt = 1'b1;
        tick();
        Rec_butt = 1'b0;
        tick();
        wait_for(sess_base + 1, 31);
        tick();
`ifdef STOP_AT_END_EN
        push_chk("end_addr_finish", {30'd0, cs_n, busy}, {30'd0, 1'b1, 1'b1});
        tick();
        push_chk("end_addr_idle", {30'd0, cs_n, busy}, {30'd0, 1'b1, 1'b0});
`else
        push_chk("end_addr_continue", {26'd0, cs_n, thirty_two_count}, 32'd0);
        wait_for(sess_base + 2, 4);
        Stop_butt = 1'b1;
        tick();
        Stop_butt = 1'b0;
        wait_for(sess_base + 2, 31);
        tick();
        tick();
        push_chk("end_addr_idle", {30'd0, cs_n, busy}, {30'd0, 1'b1, 1'b0});
`endif
    endtask

    initial begin
        bit last_rst;
        bit r;
        int nc, kk;
        for (int i = 0; i < 8; i++) sess_addr[i] = 16'h8000;
        #3;
        push_chk("reset_ctrl", {27'd0, sdo, cs_n, busy, prepacket, sample_valid}, {27'd0, 5'b01000});
        push_chk("reset_count", {27'd0, thirty_two_count}, 32'd0);
        push_chk("reset_sample", {24'd0, sample_out}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        Stop_butt = 1'b1;
        tick();
        Stop_butt = 1'b0;
        push_chk("stop_in_idle", {30'd0, cs_n, busy}, {30'd0, 1'b1, 1'b0});

        session(1'b0, 1'b0, 16'h8000, 8'hA5, 8'h00, 3, 1'b0, 5);
        session(1'b1, 1'b0, 16'h8000, 8'h77, 8'h3C, 2, 1'b0, 20);
        session(1'b0, 1'b1, 16'h8000, 8'h5A, 8'h00, 2, 1'b1, 17);
        session(1'b1, 1'b0, 16'h8000, 8'h11, 8'hC3, 2, 1'b0, 9);
        end_addr_test();

        last_rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            r  = ($urandom % 3) == 0;
            nc = r ? int'($urandom % 3) : 1 + int'($urandom % 3);
            kk = r ? 1 + int'($urandom % 30) : int'($urandom % 31);
            session(1'($urandom), 1'($urandom), rand_addr(), 8'($urandom), 8'($urandom), nc, r, kk);
            last_rst = r;
        end
        if (last_rst) session(1'b0, 1'b0, rand_addr(), 8'h42, 8'h00, 1, 1'b0, 3);

        session(1'b1, 1'b0, 16'h8000, 8'h00, 8'hE7, 2, 1'b1, 10);
        word_q.delete();
        samp_q.delete();
        #1 reset = 1'b0;
        #1;
        push_chk("async_reset_ctrl", {27'd0, sdo, cs_n, busy, prepacket, sample_valid}, {27'd0, 5'b01000});
        push_chk("async_reset_count", {27'd0, thirty_two_count}, 32'd0);
        push_chk("async_reset_sample", {24'd0, sample_out}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        push_chk("idle_after_reset", {30'd0, cs_n, busy}, {30'd0, 1'b1, 1'b0});

        repeat (4) tick();
        push_chk("packets_outstanding", word_q.size(), 32'd0);
        push_chk("samples_outstanding", samp_q.size(), 32'd0);
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Serial packet engine directly upstream of the flash address counter.
- Frames 32-bit MSB-first packets (8-bit opcode, 16-bit address, 8-bit data) onto the serial memory bus.
- Produces the per-bit count (thirty_two_count) and the one-cycle prepacket pulse that advance the address counter.
- In PLAY mode, captures the returned data byte into sample_out.

Parameters:
- REC_OP, 8'h02, opcode used for record-mode data packets.
- PLAY_OP, 8'h03, opcode used for play-mode data packets.
- SETUP_OP, 8'h06, opcode of the single setup packet sent after start.
- END_ADDR, 16'd62720, last packet address; used only by the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- Rec_butt  in  1  one-cycle start-record pulse, already debounced.
- Play_butt  in  1  one-cycle start-play pulse, already debounced.
- Stop_butt  in  1  one-cycle stop request.
- address  in  16  current packet address from the address counter.
- sample_in  in  8  record data byte.
- sdi  in  1  serial data from memory.
- sdo  out  1  serial data to memory.
- cs_n  out  1  memory chip select, active low.
- thirty_two_count  out  5  bit index within current packet, 0..31.
- prepacket  out  1  one-cycle pulse on the last bit of the setup packet.
- sample_out  out  8  last byte read in PLAY mode.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values (reset==0, asynchronous): state IDLE, sdo 0, cs_n 1, thirty_two_count 0, prepacket 0, sample_out 8'h00, sample_valid 0, busy 0, mode RECORD.
- States: IDLE, GAP, SETUP, STREAM, FINISH.
- IDLE:
  - Rec_butt -> mode RECORD, go to GAP.
  - Play_butt -> mode PLAY, go to GAP.
  - Rec_butt and Play_butt in the same cycle: Rec_butt wins.
- GAP:
  - Lasts exactly 1 cycle with cs_n 1 and count 0, then go to SETUP.
  - Gives the address counter a cycle to reset to 16'h8000.
- Packet latch:
  - On entering SETUP or STREAM at count 0, latch a 32-bit shift register.
  - Contents: {opcode, address, data_byte}.
  - data_byte is sample_in in RECORD and 8'h00 in PLAY.
- Shifting:
  - cs_n is 0 throughout SETUP and STREAM.
  - sdo = shift_reg[31] each cycle; shift left by 1 per cycle.
  - thirty_two_count increments by 1 per cycle and wraps 31->0 (natural 5-bit rollover).
- SETUP:
  - Uses opcode SETUP_OP.
  - At count 31: prepacket = 1 for that single cycle, then go to STREAM with count 0.
- STREAM:
  - Uses opcode REC_OP or PLAY_OP according to mode.
  - Packets run back to back with no gap.
  - A new packet latches at each count 0.
  - The address is sampled at count 0, i.e. after the counter's update at the previous count 31.
- PLAY capture:
  - During counts 24..31, shift sdi into an 8-bit capture register.
  - On the cycle after count 31: sample_out = captured byte, sample_valid = 1 for 1 cycle.
  - No capture in SETUP or RECORD.
- Stop_butt:
  - Any time in SETUP or STREAM, set a stop flag.
  - At the next count 31 go to FINISH. The current packet always completes.
  - FINISH: cs_n 1, count 0 for 1 cycle, then IDLE.
- Restart mid-operation:
  - Rec_butt or Play_butt in SETUP or STREAM aborts the current packet immediately and goes to GAP with the new mode.
  - Partial packet is discarded; no prepacket and no sample_valid.
- Other rules:
  - Stop_butt and a start button in the same cycle: the start button wins.
  - Stop_butt in IDLE is ignored.
- Reset assertion mid-packet returns all outputs to their reset values immediately, without waiting for a clock.

Optional Feature:
- Macro STOP_AT_END_EN.
- Defined: in STREAM, when address == END_ADDR at packet start, the stop flag is set automatically. That packet completes, then FINISH -> IDLE.
- Undefined: streaming continues indefinitely; address wrap is handled by the address counter.

Test Plan:
- Reset low mid-stream at count 10 -> cs_n 1, count 0, busy 0, sdo 0 with no clock edge; after release, state stays IDLE.
- Rec_butt, address 16'h8000, sample_in 8'hA5 -> 1 GAP cycle.
  - Then 32 setup bits 8'h06_8000_A5, with prepacket high only at count 31.
  - Then a data packet starting 8'h02 with no gap.
- Play_butt, sdi driving 8'h3C on counts 24..31 of the first data packet -> sample_out 8'h3C and sample_valid 1 for one cycle, the cycle after count 31; none during SETUP.
- Stop_butt at count 5 of a STREAM packet -> packet completes to count 31, then cs_n 1 for one cycle, busy 0 the following cycle.
- Play_butt at count 17 during RECORD STREAM -> next cycle cs_n 1 (GAP), then SETUP; no prepacket or sample_valid from the aborted packet.
- With STOP_AT_END_EN, address 16'd62720 at packet start -> packet completes, then IDLE. Without it -> next packet starts at count 0.
